// File: rtl/riscv_ifetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the canonical NOP word.
// Optional misaligned-redirect support is selected by RISCV_IFETCH_MISALIGN_EN.
package riscv_ifetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } ifetch_state_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_ifetch_fifo.sv
// Prefetch FIFO of {pc, inst}, DEPTH entries; head visible the cycle after push.
// Push is refused only when full without a simultaneous pop; flush empties it.
module riscv_ifetch_fifo #(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            x_reset,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [31:0]     push_inst,
   input  logic            pop,
   input  logic            flush,
   output logic [CW-1:0]   count,
   output logic [XLEN-1:0] rd_pc,
   output logic [31:0]     rd_inst
);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge x_reset) begin
      if (!x_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observed through count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         pc_mem[wr_ptr]   <= push_pc;
         inst_mem[wr_ptr] <= push_inst;
      end
   end

   assign rd_pc   = pc_mem[rd_ptr];
   assign rd_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch front end: pipelined imem requests, in-order responses, prefetch FIFO.
// Optional macro RISCV_IFETCH_MISALIGN_EN adds inst_misalign and a HALT state.
module riscv_ifetch
   import riscv_ifetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            x_reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc_plus4
`ifdef RISCV_IFETCH_MISALIGN_EN
   ,
   output logic            inst_misalign
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 2;

   ifetch_state_t   state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redir_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [SW-1:0]   credit_used;
   logic [XLEN-1:0] fifo_pc;
   logic [31:0]     fifo_inst;
   logic            req_fire;
   logic            rsp_keep;
   logic            rsp_drop;
   logic            fifo_pop;

`ifdef RISCV_IFETCH_MISALIGN_EN
   logic            misalign;
   logic [XLEN-1:0] halt_pc;
   assign misalign = (redirect_pc[1:0] != 2'b00);
   assign redir_pc = redirect_pc;
`else
   assign redir_pc = redirect_pc & ~XLEN'(3);
`endif

   // Every slot is either in the FIFO, awaited, or owed to a flushed request.
   assign credit_used    = SW'(fifo_count) + SW'(inflight) + SW'(drop_cnt);
   assign imem_req_valid = (state == FETCH) && (credit_used < SW'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
   assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
   assign fifo_pop       = inst_ready && (state != HALT);

   always_ff @(posedge clk or negedge x_reset) begin
      if (!x_reset) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
`ifdef RISCV_IFETCH_MISALIGN_EN
         halt_pc  <= '0;
`endif
      end else if (redirect_valid) begin
         fetch_pc <= redir_pc;
         resp_pc  <= redir_pc;
         inflight <= '0;
         drop_cnt <= drop_cnt + inflight - CW'(imem_rsp_valid);
`ifdef RISCV_IFETCH_MISALIGN_EN
         halt_pc  <= redirect_pc;
         state    <= misalign ? HALT : FETCH;
`else
         state    <= FETCH;
`endif
      end else begin
         if (state == BOOT) state <= FETCH;
         if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
         if (rsp_keep) resp_pc <= resp_pc + XLEN'(4);
         if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
         inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
      end
   end

   riscv_ifetch_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .x_reset   (x_reset),
      .push      (rsp_keep),
      .push_pc   (resp_pc),
      .push_inst (imem_rsp_data),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .rd_pc     (fifo_pc),
      .rd_inst   (fifo_inst)
   );

   always_comb begin
      inst_valid = (fifo_count != '0);
      inst_data  = inst_valid ? fifo_inst : '0;
      inst_pc    = inst_valid ? fifo_pc : '0;
`ifdef RISCV_IFETCH_MISALIGN_EN
      inst_misalign = 1'b0;
      if (state == HALT) begin
         inst_valid    = 1'b1;
         inst_data     = '0;
         inst_pc       = halt_pc;
         inst_misalign = 1'b1;
      end
`endif
      inst_pc_plus4 = inst_valid ? (inst_pc + XLEN'(4)) : '0;
   end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch with an in-order variable-latency memory model.
module tb_riscv_ifetch;

   logic        clk;
   logic        x_reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus4;
   logic        tb_mis;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] acc_log[$];
   logic [31:0] pc_log[$];
   int          cyc      = 0;
   int          lat      = 1;
   int          stale    = 0;
   int          bad_data = 0;
   logic [31:0] min_pc   = 0;
   logic        found;

   riscv_ifetch dut (
      .clk            (clk),
      .x_reset        (x_reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc_plus4  (inst_pc_plus4)
`ifdef RISCV_IFETCH_MISALIGN_EN
      ,
      .inst_misalign  (tb_mis)
`endif
   );

`ifndef RISCV_IFETCH_MISALIGN_EN
   assign tb_mis = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: answers in order, lat cycles after accept, data = ~addr.
   always @(negedge clk) begin
      cyc++;
      if (x_reset && mq.size() != 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~mq[0].addr;
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      if (!x_reset) begin
         mq.delete();
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            acc_log.push_back(imem_req_addr);
         end
         if (inst_valid && !tb_mis) begin
            if (inst_data != ~inst_pc) bad_data++;
            if (inst_pc < min_pc) stale++;
            if (inst_ready && !redirect_valid) pc_log.push_back(inst_pc);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc_wait();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      x_reset        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      min_pc         = '0;
      repeat (2) @(negedge clk);
      acc_log.delete();
      pc_log.delete();
      x_reset = 1'b1;
      #2;
   endtask

   task automatic wait_inst(input int max_cyc, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         cyc_wait();
         seen = inst_valid;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      x_reset        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      #12;
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_inst_pc4", inst_pc_plus4, 0);

      // 1: streaming with a 1-cycle memory
      lat = 1; inst_ready = 1'b1;
      do_reset();
      check("t1_boot_noreq", imem_req_valid, 0);
      cyc_wait();
      check("t1_req0", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
      cyc_wait();
      check("t1_req4", {imem_req_valid, imem_req_addr}, {1'b1, 32'h4});
      check("t1_no_inst_yet", inst_valid, 0);
      cyc_wait();
      check("t1_first_valid", inst_valid, 1);
      check("t1_first_pc", inst_pc, 32'h0);
      check("t1_first_pc4", inst_pc_plus4, 32'h4);
      check("t1_first_data", inst_data, 32'hFFFF_FFFF);
      for (int i = 1; i < 6; i++) begin
         cyc_wait();
         check("t1_stream", {inst_valid, inst_pc}, {1'b1, 32'(4 * i)});
      end

      // 2: decode stalled, FIFO fills to DEPTH
      inst_ready = 1'b0;
      do_reset();
      repeat (8) cyc_wait();
      check("t2_acc_cnt", acc_log.size(), 4);
      check("t2_acc3", (acc_log.size() > 3) ? acc_log[3] : 32'hDEAD_BEEF, 32'hC);
      check("t2_req_stall", imem_req_valid, 0);
      check("t2_head_hold", {inst_valid, inst_pc}, {1'b1, 32'h0});
      @(negedge clk); inst_ready = 1'b1; #2;
      repeat (10) cyc_wait();
      check("t2_pc0", (pc_log.size() > 0) ? pc_log[0] : 32'hDEAD_BEEF, 32'h0);
      check("t2_pc1", (pc_log.size() > 1) ? pc_log[1] : 32'hDEAD_BEEF, 32'h4);
      check("t2_pc2", (pc_log.size() > 2) ? pc_log[2] : 32'hDEAD_BEEF, 32'h8);
      check("t2_pc3", (pc_log.size() > 3) ? pc_log[3] : 32'hDEAD_BEEF, 32'hC);
      check("t2_resume", (acc_log.size() > 4) ? acc_log[4] : 32'hDEAD_BEEF, 32'h10);

      // 3: request held stable while memory is not ready
      inst_ready = 1'b1;
      do_reset();
      cyc_wait();
      cyc_wait();
      @(negedge clk); imem_req_ready = 1'b0; #2;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8});
         if (i < 4) cyc_wait();
      end
      @(negedge clk); imem_req_ready = 1'b1; #2;
      cyc_wait();
      check("t3_after", {imem_req_valid, imem_req_addr}, {1'b1, 32'hC});

      // 4: redirect with two requests in flight to a 3-cycle memory
      lat = 3;
      do_reset();
      cyc_wait();
      cyc_wait();
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
      check("t4_redir_noreq", imem_req_valid, 0);
      @(negedge clk); redirect_valid = 1'b0; min_pc = 32'h100; #2;
      check("t4_req_new", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
      wait_inst(20, found);
      check("t4_inst_seen", found, 1);
      check("t4_inst_pc", inst_pc, 32'h100);
      repeat (4) cyc_wait();

      // 5: asynchronous reset with three buffered entries
      lat = 1; inst_ready = 1'b0;
      do_reset();
      repeat (5) cyc_wait();
      check("t5_pre_valid", {inst_valid, inst_data}, {1'b1, 32'hFFFF_FFFF});
      #1; x_reset = 1'b0; #1;
      check("t5_async_valid", inst_valid, 0);
      check("t5_async_data", inst_data, 0);
      check("t5_async_pc4", inst_pc_plus4, 0);
      @(negedge clk);
      @(negedge clk);
      acc_log.delete(); pc_log.delete();
      x_reset = 1'b1; inst_ready = 1'b1; #2;
      cyc_wait();
      check("t5_restart", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
      repeat (4) cyc_wait();

      // 6: redirect to a misaligned address
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h102; #2;
      check("t6_redir_noreq", imem_req_valid, 0);
`ifdef RISCV_IFETCH_MISALIGN_EN
      @(negedge clk); redirect_valid = 1'b0; #2;
      check("t6_mis", {tb_mis, inst_valid}, {1'b1, 1'b1});
      check("t6_mis_pc", inst_pc, 32'h102);
      check("t6_mis_data", inst_data, 0);
      for (int i = 0; i < 4; i++) begin
         cyc_wait();
         check("t6_halt", {imem_req_valid, tb_mis, inst_pc}, {1'b0, 1'b1, 32'h102});
      end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
      @(negedge clk); redirect_valid = 1'b0; min_pc = 32'h200; #2;
      check("t6_unhalt", {tb_mis, imem_req_valid, imem_req_addr}, {1'b0, 1'b1, 32'h200});
      wait_inst(10, found);
      check("t6_inst_pc", {found, inst_pc}, {1'b1, 32'h200});
`else
      @(negedge clk); redirect_valid = 1'b0; min_pc = 32'h100; #2;
      check("t6_req_masked", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
      wait_inst(10, found);
      check("t6_inst_pc", {found, inst_pc}, {1'b1, 32'h100});
`endif
      repeat (4) cyc_wait();

      check("stale_pc_count", stale, 0);
      check("bad_data_count", bad_data, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
